// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter that shares one combinational lookup ROM between two
// requesters and returns the registered read data with a one-cycle valid pulse.
//
// Handshake: a requester raises reqN with addrN and keeps both stable until
// it sees rvalidN for one cycle. reqN must drop before the third edge after
// the grant, or it is sampled again as a new request. The address is latched
// at the grant edge, so later changes have no effect on that transaction.
module rom_access_arbiter #(
  parameter int NBITS_ADDR = 2,
  parameter int NBITS_DATA = 4,
  parameter int NBITS_CNT  = 4
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [NBITS_ADDR-1:0] addr0,
  input  logic                  req1,
  input  logic [NBITS_ADDR-1:0] addr1,
  output logic [NBITS_ADDR-1:0] rom_addr,
  input  logic [NBITS_DATA-1:0] rom_data,
  output logic [NBITS_DATA-1:0] rdata,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic                  owner,
  output logic                  busy,
  output logic [NBITS_CNT-1:0]  done_cnt,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic                    last_served, last_served_nxt;
  logic                    owner_nxt;
  logic [NBITS_ADDR-1:0]   rom_addr_nxt;
  logic [NBITS_DATA-1:0]   rdata_nxt;
  logic                    rvalid0_nxt, rvalid1_nxt;
  logic [NBITS_CNT-1:0]    done_cnt_nxt;
  logic                    any_req;
  logic                    winner;

  // On contention the port that was not served last wins; a lone requester
  // wins regardless of history.
  always_comb begin
    any_req = req0 | req1;
    winner  = (req0 && req1) ? ~last_served : req1;
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rom_addr    <= '0;
      rdata       <= '0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      owner       <= 1'b0;
      last_served <= 1'b1;
      done_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      rom_addr    <= rom_addr_nxt;
      rdata       <= rdata_nxt;
      rvalid0     <= rvalid0_nxt;
      rvalid1     <= rvalid1_nxt;
      owner       <= owner_nxt;
      last_served <= last_served_nxt;
      done_cnt    <= done_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    rom_addr_nxt    = rom_addr;
    rdata_nxt       = rdata;
    rvalid0_nxt     = 1'b0;
    rvalid1_nxt     = 1'b0;
    owner_nxt       = owner;
    last_served_nxt = last_served;
    done_cnt_nxt    = done_cnt;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          owner_nxt    = winner;
          rom_addr_nxt = winner ? addr1 : addr0;
          state_nxt    = READ;
        end
      end
      READ: begin
        rdata_nxt   = rom_data;
        rvalid0_nxt = ~owner;
        rvalid1_nxt = owner;
        state_nxt   = RESP;
      end
      RESP: begin
        last_served_nxt = owner;
        done_cnt_nxt    = done_cnt + NBITS_CNT'(1);
        state_nxt       = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Bench for rom_access_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_rom_access_arbiter;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [1:0] addr0, addr1;
  logic [1:0] rom_addr;
  logic [3:0] rom_data;
  logic [3:0] rdata;
  logic       rvalid0, rvalid1, owner, busy;
  logic [3:0] done_cnt;
  logic [1:0] state_dbg;

  logic [3:0] rom_tbl [4];
  int         checks = 0;
  int         errors = 0;

  rom_access_arbiter dut (
    .clk_2(clk_2), .reset(reset),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .rom_addr(rom_addr), .rom_data(rom_data), .rdata(rdata),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .owner(owner), .busy(busy),
    .done_cnt(done_cnt), .state_dbg(state_dbg)
  );

  // clock / ROM model
  always #5 clk_2 = ~clk_2;
  assign rom_data = rom_tbl[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_2);
    @(negedge clk_2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] e_addr, input logic [3:0] e_rdata,
                            input logic e_rv0, input logic e_rv1, input logic e_owner,
                            input logic e_busy, input logic [3:0] e_done);
    check({tag, ".rom_addr"}, 32'(rom_addr), 32'(e_addr));
    check({tag, ".rdata"},    32'(rdata),    32'(e_rdata));
    check({tag, ".rvalid0"},  32'(rvalid0),  32'(e_rv0));
    check({tag, ".rvalid1"},  32'(rvalid1),  32'(e_rv1));
    check({tag, ".owner"},    32'(owner),    32'(e_owner));
    check({tag, ".busy"},     32'(busy),     32'(e_busy));
    check({tag, ".done_cnt"}, 32'(done_cnt), 32'(e_done));
  endtask

  typedef struct {
    logic       rst;
    logic       r0;
    logic [1:0] a0;
    logic       r1;
    logic [1:0] a1;
    logic [1:0] e_addr;
    logic [3:0] e_rdata;
    logic       e_rv0;
    logic       e_rv1;
    logic       e_owner;
    logic       e_busy;
    logic [3:0] e_done;
  } vec_t;

  vec_t vecs [10];

  // reference-model state for the randomized run
  int         next_edge, g_edge, done_m;
  logic       ls_m, g_port, pend0, pend1;
  logic [1:0] g_addr;
  logic [3:0] m_rdata;
  logic [4:0] exp_q [$];
  logic [4:0] exp_item;

  initial begin
    rom_tbl[0] = 4'b0011; rom_tbl[1] = 4'b0110;
    rom_tbl[2] = 4'b1001; rom_tbl[3] = 4'b1100;
    addr0 = '0; addr1 = '0;

    // rst r0 a0 r1 a1 | addr rdata rv0 rv1 own busy done
    vecs[0] = '{1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd2, 4'h0,    1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[1] = '{1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd2, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[2] = '{1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 2'd2, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
    vecs[3] = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 4'h0,    1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[4] = '{1'b0, 1'b1, 2'd1, 1'b1, 2'd3, 2'd1, 4'h0,    1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[5] = '{1'b0, 1'b1, 2'd1, 1'b1, 2'd3, 2'd1, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[6] = '{1'b0, 1'b0, 2'd1, 1'b1, 2'd3, 2'd1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
    vecs[7] = '{1'b0, 1'b0, 2'd1, 1'b1, 2'd3, 2'd3, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1};
    vecs[8] = '{1'b0, 1'b0, 2'd1, 1'b1, 2'd3, 2'd3, 4'b1100, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1};
    vecs[9] = '{1'b0, 1'b0, 2'd1, 1'b0, 2'd3, 2'd3, 4'b1100, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2};

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    #12;
    check_outs("reset", 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk_2);
    reset = 1'b0;

    // directed vectors: single read, then reset and simultaneous requests
    for (int i = 0; i < 10; i++) begin
      reset = vecs[i].rst;
      req0 = vecs[i].r0; addr0 = vecs[i].a0;
      req1 = vecs[i].r1; addr1 = vecs[i].a1;
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_rdata, vecs[i].e_rv0,
                 vecs[i].e_rv1, vecs[i].e_owner, vecs[i].e_busy, vecs[i].e_done);
    end
    reset = 1'b0;

    // both ports held high: strict alternation starting with port 0
    do_reset();
    req0 = 1'b1; addr0 = 2'd1; req1 = 1'b1; addr1 = 2'd2;
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("alt.rv0.%0d", k), 32'(rvalid0), 32'((k % 3 == 1) && ((k / 3) % 2 == 0)));
      check($sformatf("alt.rv1.%0d", k), 32'(rvalid1), 32'((k % 3 == 1) && ((k / 3) % 2 == 1)));
      if (k % 3 == 0) check($sformatf("alt.owner.%0d", k), 32'(owner), 32'((k / 3) % 2));
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    check("alt.done", 32'(done_cnt), 32'd4);

    // lone requester on port 1, back-to-back
    do_reset();
    req1 = 1'b1; addr1 = 2'd2;
    for (int k = 0; k < 15; k++) begin
      step();
      check($sformatf("lone.rv0.%0d", k), 32'(rvalid0), 32'd0);
      check($sformatf("lone.rv1.%0d", k), 32'(rvalid1), 32'(k % 3 == 1));
    end
    req1 = 1'b0;
    check("lone.done", 32'(done_cnt), 32'd5);

    // address change after grant is ignored
    do_reset();
    req0 = 1'b1; addr0 = 2'd0;
    step();
    addr0 = 2'd3;
    step();
    check("latch.rdata", 32'(rdata), 32'b0011);
    check("latch.rv0", 32'(rvalid0), 32'd1);
    req0 = 1'b0;
    step();

    // reset during READ aborts the transaction
    req0 = 1'b1; addr0 = 2'd2;
    step();
    check("abort.busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_outs("abort", 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    req0 = 1'b0;
    step();
    check("abort.rv0", 32'(rvalid0), 32'd0);
    check("abort.rv1", 32'(rvalid1), 32'd0);
    reset = 1'b0;

    // done_cnt wraps after 16 transactions
    do_reset();
    req0 = 1'b1; addr0 = 2'd1;
    for (int k = 0; k < 48; k++) begin
      step();
      if (k == 44) check("wrap.done15", 32'(done_cnt), 32'd15);
    end
    req0 = 1'b0;
    check("wrap.done0", 32'(done_cnt), 32'd0);
    check("wrap.rdata", 32'(rdata), 32'b0110);

    // randomized traffic against a transaction-level model
    do_reset();
    next_edge = 0; g_edge = -10; done_m = 0; ls_m = 1'b1;
    g_port = 1'b0; g_addr = 2'd0; m_rdata = 4'h0; pend0 = 1'b0; pend1 = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 600; k++) begin
      if (k >= next_edge && (req0 || req1)) begin
        g_port = (req0 && req1) ? ~ls_m : req1;
        g_addr = g_port ? addr1 : addr0;
        ls_m = g_port;
        g_edge = k;
        next_edge = k + 3;
        exp_q.push_back({g_port, rom_tbl[g_addr]});
      end
      if (k == g_edge + 1) m_rdata = rom_tbl[g_addr];
      if (k == g_edge + 2) done_m = (done_m + 1) % 16;
      step();
      check("rnd.rv0", 32'(rvalid0), 32'((k == g_edge + 1) && !g_port));
      check("rnd.rv1", 32'(rvalid1), 32'((k == g_edge + 1) && g_port));
      check("rnd.busy", 32'(busy), 32'((k == g_edge) || (k == g_edge + 1)));
      check("rnd.owner", 32'(owner), 32'(g_port));
      check("rnd.rom_addr", 32'(rom_addr), 32'(g_addr));
      check("rnd.rdata", 32'(rdata), 32'(m_rdata));
      check("rnd.done", 32'(done_cnt), 32'(done_m));
      if (rvalid0 || rvalid1) begin
        if (exp_q.size() == 0) begin
          check("rnd.unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          exp_item = exp_q.pop_front();
          check("rnd.response", 32'({rvalid1, rdata}), 32'(exp_item));
        end
      end
      if (pend0 && rvalid0) begin
        req0 = 1'b0; pend0 = 1'b0;
      end else if (!pend0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; pend0 = 1'b1; addr0 = 2'($urandom_range(0, 3));
      end
      if (pend1 && rvalid1) begin
        req1 = 1'b0; pend1 = 1'b0;
      end else if (!pend1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; pend1 = 1'b1; addr1 = 2'($urandom_range(0, 3));
      end
    end
    check("rnd.queue_left", 32'(exp_q.size() <= 1), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_access_arbiter.md
Name: rom_access_arbiter

Overview:
- Shares one combinational 4-entry x 4-bit lookup ROM (address in, data out) between two requesters.
- Arbitrates round-robin, latches the winner's address, drives the ROM address, registers the ROM data and returns it with a one-cycle valid pulse.
- Sits between the ROM and its users in top; its outputs are suitable for LED/LCD debug display.

Parameters:
NBITS_ADDR, 2, ROM address width
NBITS_DATA, 4, ROM data width
NBITS_CNT, 4, width of completed-transaction counter

Ports:
clk_2  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req0  input  1  request from port 0, level, held until rvalid0
addr0  input  NBITS_ADDR  port 0 read address
req1  input  1  request from port 1, level, held until rvalid1
addr1  input  NBITS_ADDR  port 1 read address
rom_addr  output  NBITS_ADDR  registered address driven to ROM
rom_data  input  NBITS_DATA  combinational ROM output for rom_addr
rdata  output  NBITS_DATA  registered read data, shared by both ports
rvalid0  output  1  one-cycle pulse: rdata valid for port 0
rvalid1  output  1  one-cycle pulse: rdata valid for port 1
owner  output  1  port currently/last granted
busy  output  1  high when FSM not IDLE
done_cnt  output  NBITS_CNT  completed transactions, wraps

Behaviour:
- Reset (async, immediate): state=IDLE, rom_addr=0, rdata=0, rvalid0=rvalid1=0, owner=0, last_served=1 (port 0 has first priority), done_cnt=0.
- FSM states IDLE, READ, RESP; all outputs registered except busy = (state != IDLE).
- IDLE: sample req0/req1 each edge.
  - Neither: stay IDLE.
  - Only one: grant it.
  - Both: grant the port != last_served.
  - On grant: owner <= winner, rom_addr <= winner's addr, state <= READ.
- READ: rom_addr held stable. At the edge: rdata <= rom_data, rvalid[owner] <= 1, state <= RESP.
- RESP: rvalid high this cycle only. At the edge: rvalid <= 0, last_served <= owner, done_cnt <= done_cnt+1 (mod 2^NBITS_CNT), state <= IDLE.
- Latency: request sampled at edge E0; rdata/rvalid valid after E1; IDLE again after E2; next sample at E3. Peak throughput is one transaction per 3 cycles.
- Requester protocol:
  - Keep req and addr stable until rvalid is seen.
  - Deassert req before edge E3, otherwise it is treated as a new request.
  - Address changes after E0 are ignored; the latched address is used.
- Non-requesting port: its rvalid never asserts. rdata holds its last value between transactions.
- Lone requester: served back-to-back regardless of last_served; round-robin only matters on contention.
- Reset mid-transaction (READ or RESP): transaction aborted, no rvalid, done_cnt=0, reset values restored.
- done_cnt wraps from 2^NBITS_CNT-1 to 0 with no flag.
- req deasserted while in READ/RESP: the transaction still completes and pulses rvalid.

Test Plan:
Bench ROM model contents: addr0=4'b0011, addr1=4'b0110, addr2=4'b1001, addr3=4'b1100.
1. Reset, then req0=1, addr0=2 sampled at E0 -> rom_addr=2 after E0; rdata=4'b1001, rvalid0=1, rvalid1=0 after E1; done_cnt=1 and busy=0 after E2.
2. Right after reset, req0 and req1 rise in the same cycle, addr0=1, addr1=3 -> port 0 served first (rdata=4'b0110, rvalid0); port 1 next (rdata=4'b1100, rvalid1) 3 cycles later; done_cnt=2.
3. req0 and req1 held high for 12 cycles -> owner alternates 0,1,0,1; rvalid pulses every 3 cycles; never two consecutive grants to one port.
4. Only req1 requests, five times back-to-back -> five rvalid1 pulses spaced 3 cycles apart; rvalid0 stays 0; done_cnt=5.
5. req0 with addr0=0, then addr0 changed to 3 during READ -> rdata=4'b0011 (latched address); a reset asserted during READ of a later transaction gives no rvalid and all outputs at reset values. Separately, 16 completed transactions -> done_cnt wraps to 0.
